multi_cycle_control_unit: RTL and testbench

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

---
 rtl/multi_cycle_control_unit.sv | 133 +++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: IF/ID/EX/MEM/WB/HALT sequencer for a multi-cycle RV32 datapath with retire counter
module multi_cycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        halt_cond,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctrl_op,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        is_halted,
    output logic [31:0] retire_count
);
    localparam logic [6:0] ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] LOAD           = 7'b0000011;
    localparam logic [6:0] STORE          = 7'b0100011;
    localparam logic [6:0] BRANCH         = 7'b1100011;
    localparam logic [6:0] JAL            = 7'b1101111;
    localparam logic [6:0] JALR           = 7'b1100111;
    localparam logic [6:0] ECALL          = 7'b1110011;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl_op;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       is_halted;
    } ctl_t;

    state_t state, next;
    ctl_t   c;
    logic   known;

    assign known = opcode inside {ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL};

    always_comb begin
        c    = '0;
        next = state;
        case (state)
            S_IF: begin
                c.mem_read = 1'b1;
                c.ir_write = mem_ready;
                next       = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.pc_write  = !known || (opcode == ECALL && !halt_cond);
                next        = (opcode == ECALL) ? (halt_cond ? S_HALT : S_IF) : (known ? S_EX : S_IF);
            end
            S_EX: begin
                next = S_WB;
                case (opcode)
                    ARITHMETIC: begin
                        c.alu_src_a   = 1'b1;
                        c.alu_ctrl_op = 2'b10;
                    end
                    ARITHMETIC_IMM: begin
                        c.alu_src_a   = 1'b1;
                        c.alu_src_b   = 2'b10;
                        c.alu_ctrl_op = 2'b11;
                    end
                    LOAD, STORE: begin
                        c.alu_src_a = 1'b1;
                        c.alu_src_b = 2'b10;
                        next        = S_MEM;
                    end
                    BRANCH: begin
                        c.alu_src_a   = 1'b1;
                        c.alu_ctrl_op = 2'b01;
                        c.pc_write    = 1'b1;
                        c.pc_source   = bcond ? 2'b10 : 2'b00;
                        next          = S_IF;
                    end
                    JALR: begin
                        c.alu_src_a = 1'b1;
                        c.alu_src_b = 2'b10;
                    end
                    default: next = (opcode == JAL) ? S_WB : S_IF;
                endcase
            end
            S_MEM: begin
                c.i_or_d    = 1'b1;
                c.mem_read  = opcode == LOAD;
                c.mem_write = opcode == STORE;
                c.pc_write  = mem_ready && opcode == STORE;
                next        = !mem_ready ? S_MEM : (opcode == LOAD ? S_WB : S_IF);
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.pc_write   = 1'b1;
                c.mem_to_reg = (opcode == LOAD) ? 2'b01 : (opcode == JAL || opcode == JALR) ? 2'b10 : 2'b00;
                c.pc_source  = (opcode == JAL) ? 2'b10 : (opcode == JALR) ? 2'b01 : 2'b00;
                next         = S_IF;
            end
            default: c.is_halted = 1'b1;
        endcase
    end

    // Outputs are masked by reset so an in-flight memory request drops the moment reset asserts
    assign {mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, alu_src_a,
            alu_src_b, alu_ctrl_op, pc_write, pc_source, is_halted} = reset ? c : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IF;
            retire_count <= '0;
        end else begin
            state <= next;
            if (c.pc_write || (next == S_HALT && state != S_HALT))
                retire_count <= retire_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: randomized instruction stream checked per cycle against a queued instruction-level model
module tb_multi_cycle_control_unit;
    localparam logic [6:0] ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] LOAD           = 7'b0000011;
    localparam logic [6:0] STORE          = 7'b0100011;
    localparam logic [6:0] BRANCH         = 7'b1100011;
    localparam logic [6:0] JAL            = 7'b1101111;
    localparam logic [6:0] JALR           = 7'b1100111;
    localparam logic [6:0] ECALL          = 7'b1110011;
    localparam logic [6:0] BOGUS          = 7'b1111111;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl_op;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       is_halted;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic [6:0]  opcode = '0;
    logic        bcond = 1'b0, halt_cond = 1'b0, mem_ready = 1'b0;
    logic        mem_read, mem_write, i_or_d, ir_write, reg_write, alu_src_a, pc_write, is_halted;
    logic [1:0]  mem_to_reg, alu_src_b, alu_ctrl_op, pc_source;
    logic [31:0] retire_count;
    ctl_t        act;
    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] cnt = '0;
    int          vectors = 0, miscompares = 0;
    logic [6:0]  ops[9] = '{ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL, BOGUS};

    always #5 clk = ~clk;

    multi_cycle_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl_op(alu_ctrl_op), .pc_write(pc_write), .pc_source(pc_source),
        .is_halted(is_halted), .retire_count(retire_count)
    );

    assign act = {mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, alu_src_a,
                  alu_src_b, alu_ctrl_op, pc_write, pc_source, is_halted};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            vectors++;
            if ({act, retire_count} !== mon_e) begin
                miscompares++;
                $display("FAIL cycle@%0t opcode=%b: got ctl=%b retire=%0d, want ctl=%b retire=%0d",
                         $time, opcode, act, retire_count, mon_e.c, mon_e.cnt);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    // One clock cycle of stimulus together with the outputs the model expects during it
    task automatic step(input logic rn, input logic [6:0] op, input logic mr, input logic bc,
                        input logic hc, input ctl_t c);
        @(posedge clk);
        #1;
        reset = rn; opcode = op; mem_ready = mr; bcond = bc; halt_cond = hc;
        if (!rn) cnt = '0;
        q.push_back({c, cnt});
        if (c.pc_write) cnt++;
    endtask

    task automatic run_instr(input logic [6:0] op, input int w_if, input int w_mem,
                             input logic bc_ex, input logic hc_id, input logic abort);
        ctl_t c;
        for (int i = 0; i < w_if; i++) begin
            c = '0; c.mem_read = 1'b1;
            step(1'b1, op, 1'b0, rb(), rb(), c);
        end
        c = '0; c.mem_read = 1'b1; c.ir_write = 1'b1;
        step(1'b1, op, 1'b1, rb(), rb(), c);
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        if (op == ECALL && hc_id) begin
            step(1'b1, op, rb(), rb(), 1'b1, c);
            cnt++;
            return;
        end
        if (op == ECALL || op == BOGUS) begin
            c.pc_write = 1'b1;
            step(1'b1, op, rb(), rb(), hc_id, c);
            return;
        end
        step(1'b1, op, rb(), rb(), rb(), c);
        c = '0;
        case (op)
            ARITHMETIC:        begin c.alu_src_a = 1'b1; c.alu_ctrl_op = 2'b10; end
            ARITHMETIC_IMM:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl_op = 2'b11; end
            LOAD, STORE, JALR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_ctrl_op = 2'b01; c.pc_write = 1'b1;
                c.pc_source = bc_ex ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
        step(1'b1, op, rb(), (op == BRANCH) ? bc_ex : rb(), rb(), c);
        if (op == BRANCH) return;
        if (op == LOAD || op == STORE) begin
            c = '0; c.i_or_d = 1'b1; c.mem_read = op == LOAD; c.mem_write = op == STORE;
            for (int i = 0; i < w_mem; i++) step(1'b1, op, 1'b0, rb(), rb(), c);
            if (abort) return;
            c.pc_write = op == STORE;
            step(1'b1, op, 1'b1, rb(), rb(), c);
            if (op == STORE) return;
        end
        c = '0; c.reg_write = 1'b1; c.pc_write = 1'b1;
        c.mem_to_reg = (op == LOAD) ? 2'b01 : (op == JAL || op == JALR) ? 2'b10 : 2'b00;
        c.pc_source  = (op == JAL) ? 2'b10 : (op == JALR) ? 2'b01 : 2'b00;
        step(1'b1, op, rb(), rb(), rb(), c);
    endtask

    initial begin
        ctl_t h;
        logic [6:0] op;
        repeat (3) step(1'b0, 7'h00, rb(), rb(), rb(), '0);
        run_instr(ARITHMETIC, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(LOAD, 2, 3, 1'b0, 1'b0, 1'b0);
        run_instr(BRANCH, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr(BRANCH, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(JALR, 1, 0, 1'b0, 1'b0, 1'b0);
        run_instr(JAL, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(ARITHMETIC_IMM, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(ECALL, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(BOGUS, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(STORE, 1, 2, 1'b0, 1'b0, 1'b0);
        run_instr(STORE, 0, 2, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, STORE, rb(), rb(), rb(), '0);
        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(8)];
            run_instr(op, $urandom_range(3), $urandom_range(3), rb(), 1'b0, 1'b0);
        end
        run_instr(ECALL, 0, 0, 1'b0, 1'b1, 1'b0);
        h = '0; h.is_halted = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, ops[$urandom_range(8)], rb(), rb(), rb(), h);
        @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
